serial_tx: RTL

Parallel-in, serial-out frame transmitter for the single-wire link into the team's shift-register receive chain. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB first, framed by one start bit (0) and one stop bit (1), with each bit held for DIV clocks. It is the transmit end of the link, and its output line idles high.

---
 rtl/serial_pkg.sv | 16 +
 rtl/serial_tx_bit_timer.sv | 29 ++
 rtl/serial_tx.sv | 104 ++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared serial link definitions: FSM encoding and line levels,
// common to the transmit and receive ends.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam logic TX_IDLE_LEVEL = 1'b1;
   localparam logic START_LEVEL   = 1'b0;
   localparam logic STOP_LEVEL    = 1'b1;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period divider: tick marks the last clock of each
// DIV-clock bit period; clear restarts the period.
module bit_timer #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(DIV + 1);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB
// first, stop bit, each held DIV clocks; line idles high.
module serial_tx
   import serial_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid,
   output logic             ready,
   output logic             tx,
   output logic             busy,
   output logic             done
);

   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic             tx_d, done_d;
   logic             accept, tick;

   assign ready  = (state_q == IDLE);
   assign busy   = (state_q != IDLE);
   assign accept = ready && valid;

   bit_timer #(.DIV(DIV)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (accept),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (valid) begin
               state_d = START;
               shift_d = data_in;
               bit_d   = '0;
            end
         end
         START: begin
            if (tick) state_d = DATA;
         end
         DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_q == LAST_BIT) begin
                  state_d = STOP;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         STOP: begin
            if (tick) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // tx is registered from the next state so the line never glitches
   always_comb begin
      tx_d = TX_IDLE_LEVEL;
      unique case (state_d)
         IDLE:    tx_d = TX_IDLE_LEVEL;
         START:   tx_d = START_LEVEL;
         DATA:    tx_d = shift_d[0];
         STOP:    tx_d = STOP_LEVEL;
         default: tx_d = TX_IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         tx      <= TX_IDLE_LEVEL;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         tx      <= tx_d;
         done    <= done_d;
      end
   end

endmodule
